// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter and its round-robin picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int NUM_REQ_MAX = 4;
  localparam int IDX_W       = 2;

  // Advance the round-robin pointer past the last grant, wrapping at num_req.
  function automatic logic [IDX_W-1:0] next_rr_ptr(input logic [IDX_W-1:0] grant,
                                                   input int unsigned num_req);
    logic [IDX_W-1:0] nxt;
    if ((32'(grant) + 32'd1) >= num_req) begin
      nxt = '0;
    end else begin
      nxt = grant + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. First valid bit at or after
// rr_ptr (wrapping) wins; returns one-hot grant, its index and an any-valid flag.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic        found_s;
  int unsigned k_s;

  // Scan candidates in priority order starting at rr_ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    k_s       = 32'd0;
    for (int i = 0; i < N; i++) begin
      k_s = (32'(rr_ptr) + 32'(i)) % 32'(N);
      for (int j = 0; j < N; j++) begin
        if (!found_s && valid[j] && (32'(j) == k_s)) begin
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
          found_s   = 1'b1;
        end else begin
          found_s   = found_s;
        end
      end
    end
  end

  // Any requester pending.
  always_comb begin
    any = |valid;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer sharing one single-port memory between
// NUM_REQ requesters. Optional macro MEM_ARBITER_LOCK_EN adds req_lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_r_w,
  input  logic [NUM_REQ-1:0][ADDR-1:0]         req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_din,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]                   req_lock,
`endif
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 mem_r_w,
  output logic [ADDR-1:0]                      mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_din,
  input  logic [DATA_WIDTH-1:0]                mem_dout,
  output logic                                 busy
);

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        rr_ptr_r, grant_idx_r, pick_idx_s;
  logic [NUM_REQ-1:0]      grant_oh_r, pick_oh_s, rsp_valid_r;
  logic                    any_s, lat_r_w_r, sel_r_w_s, lock_hit_s;
  logic [ADDR-1:0]         mem_addr_r, sel_addr_s;
  logic [DATA_WIDTH-1:0]   mem_din_r, sel_din_s, rsp_data_r;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (pick_oh_s),
    .grant_idx (pick_idx_s),
    .any       (any_s)
  );

`ifdef MEM_ARBITER_LOCK_EN
  assign lock_hit_s = |(req_lock & grant_oh_r);
`else
  assign lock_hit_s = 1'b0;
`endif

  // One-hot mux of the winning requester's fields.
  always_comb begin
    sel_r_w_s  = 1'b0;
    sel_addr_s = '0;
    sel_din_s  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_oh_s[j]) begin
        sel_r_w_s  = req_r_w[j];
        sel_addr_s = req_addr[j];
        sel_din_s  = req_din[j];
      end else begin
        sel_r_w_s  = sel_r_w_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latch, memory port registers, response capture and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      grant_oh_r  <= '0;
      lat_r_w_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_din_r   <= '0;
      rsp_data_r  <= '0;
      rsp_valid_r <= '0;
    end else begin
      rsp_valid_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_idx_r <= pick_idx_s;
            grant_oh_r  <= pick_oh_s;
            lat_r_w_r   <= sel_r_w_s;
            mem_addr_r  <= sel_addr_s;
            mem_din_r   <= sel_din_s;
          end
        end
        ACCESS: begin
          if (!lat_r_w_r) begin
            rsp_data_r <= mem_dout;
          end
          rsp_valid_r <= grant_oh_r;
        end
        RESP: begin
          // A locked grantee keeps top priority for its next transaction.
          if (lock_hit_s) begin
            rr_ptr_r <= grant_idx_r;
          end else begin
            rr_ptr_r <= next_rr_ptr(grant_idx_r, 32'(NUM_REQ));
          end
        end
        default: begin
          rr_ptr_r <= rr_ptr_r;
        end
      endcase
    end
  end

  // Output gating: everything reads as zero while rst is asserted.
  always_comb begin
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      mem_r_w   = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      busy      = 1'b0;
    end else begin
      req_ready = (state_r == IDLE) ? pick_oh_s : '0;
      rsp_valid = rsp_valid_r;
      rsp_data  = rsp_data_r;
      mem_r_w   = (state_r == ACCESS) && lat_r_w_r;
      mem_addr  = mem_addr_r;
      mem_din   = mem_din_r;
      busy      = (state_r != IDLE);
    end
  end

endmodule
